tcm_mem_ram_dp: RTL and testbench

Parametrised single-clock true-dual-port TCM RAM. It generalises the 64-bit byte-enable RAM in the following ways:
- configurable data width and depth
- selectable read-during-write mode
- optional output pipeline register with per-port read-valid
- deterministic same-address collision resolution with a flag
- a post-reset zero-initialisation sequencer

It sits between the core's instruction/data TCM ports and the AXI slave port of the TCM wrapper.

---
 rtl/tcm_mem_ram_dp.sv | 154 +++++++++++++++
 tb/tb_tcm_mem_ram_dp.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcm_mem_ram_dp.sv
// True-dual-port byte-enable TCM RAM with selectable read-during-write mode,
// optional output register, collision flag and post-reset zero-clear sequencer.
module tcm_mem_ram_dp #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 8192,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter bit WRITE_FIRST = 1'b0,
  parameter bit OUT_REG     = 1'b0,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              init_busy_o,
  input  logic              req0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W/8-1:0] wr0_i,
  input  logic [DATA_W-1:0] data0_i,
  output logic [DATA_W-1:0] data0_o,
  output logic              valid0_o,
  input  logic              req1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W/8-1:0] wr1_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic [DATA_W-1:0] data1_o,
  output logic              valid1_o,
  output logic              collision_o
);

  localparam int NB = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_L  = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic              busy_reg;
  logic              coll_reg;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]                   req;
  logic [1:0][ADDR_W-1:0]       addr;
  logic [1:0][NB-1:0]           wr;
  logic [1:0][DATA_W-1:0]       wdata;
  logic [1:0][DATA_W-1:0]       dout;
  logic [1:0]                   vout;
  logic [1:0]                   take;
  logic [1:0]                   in_range;
  logic [1:0][NB-1:0]           wen;

  assign req   = {req1_i, req0_i};
  assign addr  = {addr1_i, addr0_i};
  assign wr    = {wr1_i, wr0_i};
  assign wdata = {data1_i, data0_i};

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == ST_INIT) begin
      cnt_next = cnt_reg + ADDR_W'(1);
      if (cnt_reg == LAST_L) begin
        state_next = ST_READY;
        cnt_next   = '0;
      end
    end
  end

  // busy also covers the cycle after a reset edge even when clearing is skipped
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= INIT_ZERO ? ST_INIT : ST_READY;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
      coll_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next == ST_INIT);
      coll_reg  <= ~busy_reg & req[0] & req[1] & (addr[0] == addr[1]) & ((|wr[0]) | (|wr[1]));
    end
  end

  // port 0 is written last so it owns bytes enabled on both ports
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_reg == ST_INIT) begin
        mem[cnt_reg] <= '0;
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (wen[1][b]) mem[addr[1]][8*b +: 8] <= wdata[1][8*b +: 8];
          if (wen[0][b]) mem[addr[0]][8*b +: 8] <= wdata[0][8*b +: 8];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] rd_reg;
      logic              rv_reg;

      assign take[gi]     = req[gi] & ~busy_reg;
      assign in_range[gi] = ({1'b0, addr[gi]} < DEPTH_L);
      assign wen[gi]      = wr[gi] & {NB{take[gi] & in_range[gi]}};

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          rd_reg <= '0;
          rv_reg <= 1'b0;
        end else begin
          rv_reg <= take[gi];
          if (take[gi]) begin
            for (int b = 0; b < NB; b++) begin
              if (!in_range[gi])
                rd_reg[8*b +: 8] <= 8'h00;
              else if (WRITE_FIRST && wr[gi][b])
                rd_reg[8*b +: 8] <= wdata[gi][8*b +: 8];
              else
                rd_reg[8*b +: 8] <= mem[addr[gi]][8*b +: 8];
            end
          end
        end
      end

      if (OUT_REG) begin : g_oreg
        logic [DATA_W-1:0] d2_reg;
        logic              v2_reg;
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            d2_reg <= '0;
            v2_reg <= 1'b0;
          end else begin
            v2_reg <= rv_reg;
            if (rv_reg) d2_reg <= rd_reg;
          end
        end
        assign dout[gi] = d2_reg;
        assign vout[gi] = v2_reg;
      end else begin : g_noreg
        assign dout[gi] = rd_reg;
        assign vout[gi] = rv_reg;
      end
    end
  endgenerate

  assign init_busy_o = busy_reg;
  assign collision_o = coll_reg;
  assign data0_o     = dout[0];
  assign data1_o     = dout[1];
  assign valid0_o    = vout[0];
  assign valid1_o    = vout[1];

endmodule

// File: tb/tb_tcm_mem_ram_dp.sv
// Random + directed scoreboard bench for two RAM configurations driven in lockstep:
// A = read-first, latency 1, 16 words; B = write-first, latency 2, 12 words.
module tb_tcm_mem_ram_dp;

  typedef struct packed {
    logic [63:0] d;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req0_i, req1_i;
  logic [3:0]  addr0_i, addr1_i;
  logic [7:0]  wr0_i, wr1_i;
  logic [63:0] data0_i, data1_i;

  logic        busy_a, valid0_a, valid1_a, coll_a;
  logic [63:0] data0_a, data1_a;
  logic        busy_b, valid0_b, valid1_b, coll_b;
  logic [63:0] data0_b, data1_b;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int k      = 0;
  bit started  = 1'b0;
  bit last_rst = 1'b0;

  exp_t        sb [4][$];
  bit          exp_coll [int];
  logic [63:0] mem_m [2][16];

  always #5 clk = ~clk;

  tcm_mem_ram_dp #(.DATA_W(64), .DEPTH(16), .WRITE_FIRST(1'b0), .OUT_REG(1'b0), .INIT_ZERO(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst_i), .init_busy_o(busy_a),
    .req0_i(req0_i), .addr0_i(addr0_i), .wr0_i(wr0_i), .data0_i(data0_i), .data0_o(data0_a), .valid0_o(valid0_a),
    .req1_i(req1_i), .addr1_i(addr1_i), .wr1_i(wr1_i), .data1_i(data1_i), .data1_o(data1_a), .valid1_o(valid1_a),
    .collision_o(coll_a));

  tcm_mem_ram_dp #(.DATA_W(64), .DEPTH(12), .WRITE_FIRST(1'b1), .OUT_REG(1'b1), .INIT_ZERO(1'b1)) dut_b (
    .clk_i(clk), .rst_i(rst_i), .init_busy_o(busy_b),
    .req0_i(req0_i), .addr0_i(addr0_i), .wr0_i(wr0_i), .data0_i(data0_i), .data0_o(data0_b), .valid0_o(valid0_b),
    .req1_i(req1_i), .addr1_i(addr1_i), .wr1_i(wr1_i), .data1_i(data1_i), .data1_o(data1_b), .valid1_o(valid1_b),
    .collision_o(coll_b));

  function automatic int dep(input int u);
    return (u == 0) ? 16 : 12;
  endfunction

  // Expected read value: what the addressed word holds before this cycle's writes,
  // with the port's own enabled bytes substituted in write-first mode.
  function automatic logic [63:0] model_read(input int u, input logic [3:0] a,
                                             input logic [7:0] w, input logic [63:0] d);
    logic [63:0] v;
    if (int'(a) >= dep(u)) return 64'h0;
    v = mem_m[u][a];
    if (u == 1)
      for (int b = 0; b < 8; b++)
        if (w[b]) v[8*b +: 8] = d[8*b +: 8];
    return v;
  endfunction

  task automatic model_write(input int u, input logic [3:0] a,
                             input logic [7:0] w, input logic [63:0] d);
    if (int'(a) < dep(u))
      for (int b = 0; b < 8; b++)
        if (w[b]) mem_m[u][a][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic issue(input bit r0, input logic [3:0] a0, input logic [7:0] w0, input logic [63:0] d0,
                       input bit r1, input logic [3:0] a1, input logic [7:0] w1, input logic [63:0] d1);
    exp_t e;
    logic [63:0] e0, e1;
    @(posedge clk); #1;
    req0_i = r0; addr0_i = a0; wr0_i = w0; data0_i = d0;
    req1_i = r1; addr1_i = a1; wr1_i = w1; data1_i = d1;
    for (int u = 0; u < 2; u++) begin
      e0 = model_read(u, a0, w0, d0);
      e1 = model_read(u, a1, w1, d1);
      e.due = cyc + ((u == 0) ? 1 : 2);
      if (r0) begin e.d = e0; sb[2*u].push_back(e); end
      if (r1) begin e.d = e1; sb[2*u+1].push_back(e); end
      // port 1 first so that port 0 wins shared bytes
      if (r1) model_write(u, a1, w1, d1);
      if (r0) model_write(u, a0, w0, d0);
    end
    if (r0 && r1 && a0 == a1 && ((|w0) || (|w1))) exp_coll[cyc + 1] = 1'b1;
  endtask

  task automatic idle();
    issue(1'b0, 4'd0, 8'h00, 64'h0, 1'b0, 4'd0, 8'h00, 64'h0);
  endtask

  task automatic apply_reset(input int n);
    @(posedge clk); #1;
    req0_i = 1'b0; req1_i = 1'b0; rst_i = 1'b1;
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 16; a++) mem_m[u][a] = 64'h0;
    repeat (n) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while ((busy_a || busy_b) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (busy_a || busy_b) begin
      checks++; fails++;
      $display("FAIL init_timeout: busy_a=%0b busy_b=%0b required both 0 within 64 cycles", busy_a, busy_b);
    end
  endtask

  task automatic check_port(input int idx, input logic v, input logic [63:0] d);
    exp_t e;
    if (v) begin
      checks++;
      if (sb[idx].size() == 0 || sb[idx][0].due != cyc) begin
        fails++;
        $display("FAIL unexpected_valid stream %0d cyc %0d: got valid=1 data=%h, required valid=0", idx, cyc, d);
      end else begin
        e = sb[idx].pop_front();
        if (d !== e.d) begin
          fails++;
          $display("FAIL read_data stream %0d cyc %0d: got %h, required %h", idx, cyc, d, e.d);
        end else begin
          $display("cyc %0d stream %0d read %h ok", cyc, idx, d);
        end
      end
    end else if (sb[idx].size() > 0 && sb[idx][0].due == cyc) begin
      checks++; fails++;
      e = sb[idx].pop_front();
      $display("FAIL missing_valid stream %0d cyc %0d: got valid=0, required valid=1 data=%h", idx, cyc, e.d);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s cyc %0d: got %b, required %b", name, cyc, got, req);
    end
  endtask

  task automatic check_zero(input string name, input logic [63:0] got);
    checks++;
    if (got !== 64'h0) begin
      fails++;
      $display("FAIL %s cyc %0d: got %h, required 0", name, cyc, got);
    end
  endtask

  // edge tracker: cycle count, cycles since the last reset edge, scoreboard flush on reset
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      started = 1'b1;
      last_rst = rst_i;
      if (rst_i) begin
        k = 0;
        for (int i = 0; i < 4; i++) sb[i].delete();
        exp_coll.delete();
      end else if (k < 100000) begin
        k = k + 1;
      end
    end
  end

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check_port(0, valid0_a, data0_a);
        check_port(1, valid1_a, data1_a);
        check_port(2, valid0_b, data0_b);
        check_port(3, valid1_b, data1_b);
        check_bit("init_busy_a", busy_a, k < 16);
        check_bit("init_busy_b", busy_b, k < 12);
        check_bit("collision_a", coll_a, exp_coll.exists(cyc));
        check_bit("collision_b", coll_b, exp_coll.exists(cyc));
        if (last_rst) begin
          check_zero("rst_data0_a", data0_a);
          check_zero("rst_data1_a", data1_a);
          check_zero("rst_data0_b", data0_b);
          check_zero("rst_data1_b", data1_b);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  a0, a1;
    logic [7:0]  w0, w1;
    logic [63:0] d0, d1;
    bit          r0, r1;

    rst_i = 1'b1;
    req0_i = 1'b0; addr0_i = '0; wr0_i = '0; data0_i = '0;
    req1_i = 1'b0; addr1_i = '0; wr1_i = '0; data1_i = '0;
    for (int u = 0; u < 2; u++)
      for (int a = 0; a < 16; a++) mem_m[u][a] = 64'h0;

    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    repeat (5) @(posedge clk);
    apply_reset(1);        // reset during clearing restarts it
    wait_ready();

    // every word cleared (B reads 0 beyond its depth)
    for (int a = 0; a < 16; a++)
      issue(1'b1, 4'(a), 8'h00, 64'h0, 1'b1, 4'(15 - a), 8'h00, 64'h0);
    idle();

    // byte writes then readback of addr 3
    issue(1'b1, 4'd3, 8'hFF, 64'h1122334455667788, 1'b0, 4'd0, 8'h00, 64'h0);
    issue(1'b1, 4'd3, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0, 4'd0, 8'h00, 64'h0);
    issue(1'b1, 4'd3, 8'h00, 64'h0, 1'b0, 4'd0, 8'h00, 64'h0);
    idle(); idle();

    // read-during-write on port 1, addr 5
    issue(1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd5, 8'h02, 64'hFF00);
    issue(1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd5, 8'h00, 64'h0);
    idle();

    // dual write to addr 7, then read both ports
    issue(1'b1, 4'd7, 8'h01, 64'h01, 1'b1, 4'd7, 8'h03, 64'h0202);
    issue(1'b1, 4'd7, 8'h00, 64'h0, 1'b1, 4'd7, 8'h00, 64'h0);
    idle();

    // cross-port read of addr 9
    issue(1'b1, 4'd9, 8'h01, 64'h55, 1'b0, 4'd0, 8'h00, 64'h0);
    issue(1'b1, 4'd9, 8'h01, 64'h66, 1'b1, 4'd9, 8'h00, 64'h0);
    issue(1'b0, 4'd0, 8'h00, 64'h0, 1'b1, 4'd9, 8'h00, 64'h0);
    idle(); idle();

    // random traffic with frequent same-address pairs and out-of-range B addresses
    for (int i = 0; i < 400; i++) begin
      r0 = ($urandom_range(0, 3) != 0);
      r1 = ($urandom_range(0, 3) != 0);
      a0 = 4'($urandom_range(0, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      w0 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      w1 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
      d0 = {$urandom, $urandom};
      d1 = {$urandom, $urandom};
      issue(r0, a0, w0, d0, r1, a1, w1, d1);
    end
    for (int a = 0; a < 16; a++)
      issue(1'b1, 4'(a), 8'h00, 64'h0, 1'b1, 4'(a), 8'h00, 64'h0);
    idle(); idle();

    // reset with reads in flight: B's second read must not appear
    issue(1'b1, 4'd2, 8'h00, 64'h0, 1'b1, 4'd4, 8'h00, 64'h0);
    issue(1'b1, 4'd4, 8'h00, 64'h0, 1'b1, 4'd2, 8'h00, 64'h0);
    apply_reset(1);
    wait_ready();
    for (int a = 0; a < 16; a++)
      issue(1'b1, 4'(a), 8'h00, 64'h0, 1'b1, 4'(a), 8'h00, 64'h0);
    repeat (5) idle();

    for (int i = 0; i < 4; i++) begin
      checks++;
      if (sb[i].size() != 0) begin
        fails++;
        $display("FAIL drain stream %0d: got %0d pending reads, required 0", i, sb[i].size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
